// File: rtl/osb_pkg.sv
// rtl/osb_pkg.sv - shared state encoding and width helpers for the operand stream bank
package osb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        FEED,
        DONE
    } state_e;

    function automatic int dimw_f(input int maxd);
        return $clog2(maxd + 1);
    endfunction

    function automatic int aw_f(input int maxd);
        return $clog2(maxd * maxd);
    endfunction

endpackage

// File: rtl/operand_ram.sv
// rtl/operand_ram.sv - MAXD*MAXD x DW register file, one sync write port, MAXD async read ports
module operand_ram
    import osb_pkg::*;
#(
    parameter  int DW   = 4,
    parameter  int MAXD = 3,
    localparam int AW   = aw_f(MAXD)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [DW-1:0]        wdata_i,
    input  logic [MAXD*AW-1:0]   raddr_i,
    output logic [MAXD*DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [MAXD*MAXD];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < MAXD*MAXD; a++) mem_q[a] <= '0;
        end else if (clr_i) begin
            for (int a = 0; a < MAXD*MAXD; a++) mem_q[a] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < MAXD; p++) rdata_o[p*DW +: DW] = mem_q[raddr_i[p*AW +: AW]];
    end

endmodule

// File: rtl/operand_stream_bank.sv
// rtl/operand_stream_bank.sv - loads W and X, then replays them as skewed wavefronts into the MAC array
module operand_stream_bank
    import osb_pkg::*;
#(
    parameter  int DW   = 4,
    parameter  int MAXD = 3,
    localparam int DIMW = dimw_f(MAXD),
    localparam int AW   = aw_f(MAXD)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   start,
    input  logic [DIMW-1:0]        dim_m,
    input  logic [DIMW-1:0]        dim_k,
    input  logic [DIMW-1:0]        dim_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_data,
    input  logic                   feed_en,
    output logic [MAXD*DW-1:0]     w_out,
    output logic [MAXD*DW-1:0]     x_out,
    output logic                   out_valid,
    output logic [MAXD*MAXD-1:0]   mac_en,
    output logic [MAXD*MAXD-1:0]   mac_clr,
    output logic                   done,
    output logic                   cfg_err
);

    localparam int TW = $clog2(3 * MAXD);
    localparam logic [DIMW-1:0] MAXD_D = DIMW'(MAXD);

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [TW-1:0]     t_q, t_d;
    logic [DIMW-1:0]   m_q, m_d, k_q, k_d, n_q, n_d;
    logic              cfg_err_q, cfg_err_d;
    logic              mac_clr_q, mac_clr_d;

    logic              dims_legal;
    logic [AW-1:0]     mk_last, kn_last;
    logic [TW-1:0]     t_last;
    logic              w_we, x_we;
    logic [MAXD*AW-1:0] w_raddr, x_raddr;
    logic [MAXD*DW-1:0] w_rdata, x_rdata;
    logic [MAXD-1:0]   w_ok, x_ok;

    assign dims_legal = (dim_m != '0) && (dim_m <= MAXD_D) &&
                        (dim_k != '0) && (dim_k <= MAXD_D) &&
                        (dim_n != '0) && (dim_n <= MAXD_D);
    assign mk_last    = AW'(m_q) * AW'(k_q) - AW'(1);
    assign kn_last    = AW'(k_q) * AW'(n_q) - AW'(1);
    assign t_last     = TW'(k_q) + TW'(m_q) + TW'(n_q) - TW'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            t_q       <= '0;
            m_q       <= '0;
            k_q       <= '0;
            n_q       <= '0;
            cfg_err_q <= 1'b0;
            mac_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            t_q       <= t_d;
            m_q       <= m_d;
            k_q       <= k_d;
            n_q       <= n_d;
            cfg_err_q <= cfg_err_d;
            mac_clr_q <= mac_clr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        t_d       = t_q;
        m_d       = m_q;
        k_d       = k_q;
        n_d       = n_q;
        cfg_err_d = cfg_err_q;
        mac_clr_d = 1'b0;
        if (clear) begin
            state_d   = IDLE;
            addr_d    = '0;
            t_d       = '0;
            cfg_err_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    if (dims_legal) begin
                        m_d       = dim_m;
                        k_d       = dim_k;
                        n_d       = dim_n;
                        cfg_err_d = 1'b0;
                        mac_clr_d = 1'b1;
                        addr_d    = '0;
                        state_d   = LOAD_W;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                LOAD_W: if (in_valid) begin
                    if (addr_q == mk_last) begin
                        addr_d  = '0;
                        state_d = LOAD_X;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
                LOAD_X: if (in_valid) begin
                    if (addr_q == kn_last) begin
                        addr_d  = '0;
                        t_d     = '0;
                        state_d = FEED;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
                FEED: if (feed_en) begin
                    if (t_q == t_last) begin
                        t_d     = '0;
                        state_d = DONE;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign in_ready  = ((state_q == LOAD_W) || (state_q == LOAD_X)) && !clear;
    assign w_we      = (state_q == LOAD_W) && in_valid && !clear;
    assign x_we      = (state_q == LOAD_X) && in_valid && !clear;
    assign out_valid = (state_q == FEED) && feed_en;
    assign done      = (state_q == DONE);
    assign cfg_err   = cfg_err_q;
    assign mac_clr   = {(MAXD*MAXD){mac_clr_q}};

    // Addresses are only formed once t>=lane is known, so a wrapped t-lane never reaches the store.
    always_comb begin
        w_ok    = '0;
        x_ok    = '0;
        w_raddr = '0;
        x_raddr = '0;
        for (int i = 0; i < MAXD; i++) begin
            w_ok[i] = (state_q == FEED) && (DIMW'(i) < m_q) && (t_q >= TW'(i)) &&
                      ((t_q - TW'(i)) < TW'(k_q));
            x_ok[i] = (state_q == FEED) && (DIMW'(i) < n_q) && (t_q >= TW'(i)) &&
                      ((t_q - TW'(i)) < TW'(k_q));
            if (w_ok[i]) w_raddr[i*AW +: AW] = AW'(i) * AW'(k_q) + AW'(t_q - TW'(i));
            if (x_ok[i]) x_raddr[i*AW +: AW] = AW'(t_q - TW'(i)) * AW'(n_q) + AW'(i);
        end
    end

    always_comb begin
        w_out  = '0;
        x_out  = '0;
        mac_en = '0;
        for (int i = 0; i < MAXD; i++) begin
            if (w_ok[i]) w_out[i*DW +: DW] = w_rdata[i*DW +: DW];
            if (x_ok[i]) x_out[i*DW +: DW] = x_rdata[i*DW +: DW];
            for (int j = 0; j < MAXD; j++)
                mac_en[i*MAXD+j] = out_valid && (DIMW'(i) < m_q) && (DIMW'(j) < n_q);
        end
    end

    operand_ram #(.DW(DW), .MAXD(MAXD)) u_w_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clear),
        .we_i    (w_we),
        .waddr_i (addr_q),
        .wdata_i (in_data),
        .raddr_i (w_raddr),
        .rdata_o (w_rdata)
    );

    operand_ram #(.DW(DW), .MAXD(MAXD)) u_x_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clear),
        .we_i    (x_we),
        .waddr_i (addr_q),
        .wdata_i (in_data),
        .raddr_i (x_raddr),
        .rdata_o (x_rdata)
    );

endmodule

// File: tb/tb_operand_stream_bank.sv
// tb/tb_operand_stream_bank.sv - randomized and directed bench for operand_stream_bank against a matrix-level model
module tb_operand_stream_bank;

    localparam int DW   = 4;
    localparam int MAXD = 3;
    localparam int DIMW = $clog2(MAXD + 1);

    logic                 clk = 1'b0;
    logic                 rst_n, clear, start, in_valid, feed_en;
    logic [DIMW-1:0]      dim_m, dim_k, dim_n;
    logic [DW-1:0]        in_data;
    logic                 in_ready, out_valid, done, cfg_err;
    logic [MAXD*DW-1:0]   w_out, x_out;
    logic [MAXD*MAXD-1:0] mac_en, mac_clr;

    int total = 0;
    int bad   = 0;
    int acc   = 0;
    int wv [9];
    int xv [9];

    operand_stream_bank #(.DW(DW), .MAXD(MAXD)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .feed_en(feed_en), .w_out(w_out), .x_out(x_out), .out_valid(out_valid),
        .mac_en(mac_en), .mac_clr(mac_clr), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Matrix-level model: phase 0 idle, 1 loading W, 2 loading X, 3 feeding, 4 done.
    int mph, mcnt, mt, mm, mk, mn;
    bit mcfg, mclr;
    int mw [3][3];
    int mx [3][3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mph <= 0; mcnt <= 0; mt <= 0; mcfg <= 0; mclr <= 0;
            for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) begin
                mw[r][c] <= 0; mx[r][c] <= 0;
            end
        end else begin
            mclr <= 0;
            if (clear) begin
                mph <= 0; mcnt <= 0; mt <= 0; mcfg <= 0;
                for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) begin
                    mw[r][c] <= 0; mx[r][c] <= 0;
                end
            end else if (mph == 0) begin
                if (start) begin
                    if (dim_m >= 1 && dim_m <= MAXD && dim_k >= 1 && dim_k <= MAXD &&
                        dim_n >= 1 && dim_n <= MAXD) begin
                        mm <= int'(dim_m); mk <= int'(dim_k); mn <= int'(dim_n);
                        mcfg <= 0; mclr <= 1; mph <= 1; mcnt <= 0;
                    end else begin
                        mcfg <= 1;
                    end
                end
            end else if (mph == 1) begin
                if (in_valid) begin
                    mw[mcnt / mk][mcnt % mk] <= int'(in_data);
                    if (mcnt == mm * mk - 1) begin mcnt <= 0; mph <= 2; end
                    else mcnt <= mcnt + 1;
                end
            end else if (mph == 2) begin
                if (in_valid) begin
                    mx[mcnt / mn][mcnt % mn] <= int'(in_data);
                    if (mcnt == mk * mn - 1) begin mcnt <= 0; mph <= 3; mt <= 0; end
                    else mcnt <= mcnt + 1;
                end
            end else if (mph == 3) begin
                if (feed_en) begin
                    if (mt == mk + mm + mn - 3) mph <= 4;
                    else mt <= mt + 1;
                end
            end else begin
                mph <= 0;
            end
        end
    end

    always @(posedge clk) if (rst_n && in_valid && in_ready) acc <= acc + 1;

    always @(negedge clk) begin
        logic [MAXD*DW-1:0]   ew, ex;
        logic [MAXD*MAXD-1:0] ee;
        ew = '0; ex = '0; ee = '0;
        if (mph == 3) begin
            for (int i = 0; i < MAXD; i++) begin
                if (i < mm && mt >= i && mt - i < mk) ew[i*DW +: DW] = DW'(mw[i][mt-i]);
                if (i < mn && mt >= i && mt - i < mk) ex[i*DW +: DW] = DW'(mx[mt-i][i]);
                for (int j = 0; j < MAXD; j++)
                    if (feed_en && i < mm && j < mn) ee[i*MAXD+j] = 1'b1;
            end
        end
        chk("w_out", 32'(w_out), 32'(ew));
        chk("x_out", 32'(x_out), 32'(ex));
        chk("mac_en", 32'(mac_en), 32'(ee));
        chk("mac_clr", 32'(mac_clr), mclr ? 32'h1ff : 32'h0);
        chk("in_ready", 32'(in_ready), 32'((mph == 1 || mph == 2) && !clear));
        chk("out_valid", 32'(out_valid), 32'(mph == 3 && feed_en));
        chk("done", 32'(done), 32'(mph == 4));
        chk("cfg_err", 32'(cfg_err), 32'(mcfg));
    end

    // tog: 0 feed_en always 1, 1 alternating, 2 random.  pin: 1 first 2x2x2 table, 2 the 1x3x2 case.
    task automatic run_job(input int m, input int k, input int n, input int tog,
                           input int clr_beat, input int clr_feed, input int rst_feed, input int pin);
        logic [MAXD*DW-1:0] tw [4];
        logic [MAXD*DW-1:0] tx [4];
        int steps, fin, cyc_done;
        tw[0] = 12'h001; tw[1] = 12'h032; tw[2] = 12'h040; tw[3] = 12'h000;
        tx[0] = 12'h005; tx[1] = 12'h067; tx[2] = 12'h080; tx[3] = 12'h000;
        @(posedge clk); #1;
        start = 1; dim_m = DIMW'(m); dim_k = DIMW'(k); dim_n = DIMW'(n);
        @(posedge clk); #1;
        start = 0;
        if (pin != 0) begin
            @(negedge clk);
            chk("mac_clr_pulse", 32'(mac_clr), 32'h1ff);
            @(posedge clk); #1;
        end
        feed_en = 1;
        for (int b = 0; b < m*k + k*n; b++) begin
            in_valid = 1;
            in_data  = (b < m*k) ? DW'(wv[b]) : DW'(xv[b - m*k]);
            if (b == clr_beat) begin
                clear = 1;
                @(posedge clk); #1;
                clear = 0; in_valid = 0;
                @(negedge clk);
                chk("clr_load_in_ready", 32'(in_ready), 32'h0);
                chk("clr_load_out_valid", 32'(out_valid), 32'h0);
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        steps = 0; fin = 0; cyc_done = -1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (done) begin fin = 1; cyc_done = cyc; break; end
            if (pin == 1 && cyc < 4) begin
                chk("lit_w", 32'(w_out), 32'(tw[cyc]));
                chk("lit_x", 32'(x_out), 32'(tx[cyc]));
            end
            if (pin == 2) begin
                chk("m1_w", 32'(w_out), (cyc < 3) ? 32'(cyc + 1) : 32'h0);
                chk("m1_mac_en", 32'(mac_en), 32'h003);
            end
            if (out_valid) steps++;
            @(posedge clk); #1;
            if (cyc == clr_feed) begin
                clear = 1;
                @(posedge clk); #1;
                clear = 0;
                @(negedge clk);
                chk("clr_feed_mac_en", 32'(mac_en), 32'h0);
                chk("clr_feed_out_valid", 32'(out_valid), 32'h0);
                chk("clr_feed_w", 32'(w_out), 32'h0);
                return;
            end
            if (cyc == rst_feed) begin
                #2 rst_n = 0;
                #1;
                chk("arst_out_valid", 32'(out_valid), 32'h0);
                chk("arst_mac_en", 32'(mac_en), 32'h0);
                chk("arst_w", 32'(w_out), 32'h0);
                chk("arst_x", 32'(x_out), 32'h0);
                return;
            end
            if (tog == 1) feed_en = ~feed_en;
            else if (tog == 2) feed_en = 1'($urandom % 2);
            else feed_en = 1;
        end
        chk("done_seen", 32'(fin), 32'h1);
        chk("enabled_steps", 32'(steps), 32'(m + k + n - 2));
        if (pin == 1) chk("done_after_t3", 32'(cyc_done), 32'h4);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'h0);
    endtask

    task automatic set_first;
        wv[0] = 1; wv[1] = 2; wv[2] = 3; wv[3] = 4;
        xv[0] = 5; xv[1] = 6; xv[2] = 7; xv[3] = 8;
    endtask

    initial begin
        int acc0;
        rst_n = 0; clear = 0; start = 0; in_valid = 0; feed_en = 0;
        dim_m = '0; dim_k = '0; dim_n = '0; in_data = '0;
        @(negedge clk);
        chk("rst_w", 32'(w_out), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_cfg_err", 32'(cfg_err), 32'h0);
        @(posedge clk); #1 rst_n = 1;

        set_first();
        run_job(2, 2, 2, 0, -1, -1, -1, 1);

        for (int i = 0; i < 9; i++) begin wv[i] = i + 1; xv[i] = i + 1; end
        run_job(3, 3, 3, 1, -1, -1, -1, 0);

        wv[0] = 1; wv[1] = 2; wv[2] = 3;
        for (int i = 0; i < 6; i++) xv[i] = 10 + i;
        acc = 0;
        run_job(1, 3, 2, 0, -1, -1, -1, 2);
        chk("m1_beats", 32'(acc), 32'd9);

        @(posedge clk); #1;
        start = 1; dim_m = 2'd2; dim_k = 2'd0; dim_n = 2'd2;
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        chk("bad_k_cfg_err", 32'(cfg_err), 32'h1);
        chk("bad_k_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        start = 1; dim_m = DIMW'(MAXD + 1); dim_k = 2'd2;
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        chk("bad_m_cfg_err", 32'(cfg_err), 32'h1);
        set_first();
        run_job(2, 2, 2, 0, -1, -1, -1, 1);
        chk("cfg_err_cleared", 32'(cfg_err), 32'h0);

        run_job(2, 2, 2, 0, 5, -1, -1, 0);
        run_job(2, 2, 2, 0, -1, 1, -1, 0);
        set_first();
        run_job(2, 2, 2, 0, -1, -1, -1, 1);

        run_job(2, 2, 2, 0, -1, -1, 1, 0);
        in_valid = 1; in_data = 4'hf;
        acc0 = acc;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (3) @(posedge clk);
        #1 in_valid = 0;
        chk("idle_beats_not_taken", 32'(acc), 32'(acc0));
        set_first();
        run_job(2, 2, 2, 0, -1, -1, -1, 1);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 9; i++) begin wv[i] = int'($urandom % 16); xv[i] = int'($urandom % 16); end
            run_job(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                    2, -1, -1, -1, 0);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
